// File: rtl/round_judge_pkg.sv
// Shared encodings for the rock-paper-scissors round judge: moves, result codes,
// FSM states and the default game length.
package round_judge_pkg;

    localparam logic [1:0] ROCK     = 2'd0;
    localparam logic [1:0] PAPER    = 2'd1;
    localparam logic [1:0] SCISSORS = 2'd2;
    localparam logic [1:0] INVALID  = 2'd3;

    localparam logic [1:0] RES_TIE    = 2'd0;
    localparam logic [1:0] RES_PLAYER = 2'd1;
    localparam logic [1:0] RES_AI     = 2'd2;
    localparam logic [1:0] RES_NONE   = 2'd3;

    // Must match the learner's history depth.
    localparam int MAX_ROUNDS = 60;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_AI,
        S_JUDGE,
        S_HOLD,
        S_DONE
    } state_e;

endpackage

// File: rtl/round_judge_outcome.sv
// Pure combinational outcome rule: d = (player - ai) mod 3 -> tie / player / AI.
module rps_outcome (
    input  logic [1:0] player,
    input  logic [1:0] ai,
    output logic [1:0] result
);
    import round_judge_pkg::*;

    always_comb begin
        result = RES_NONE;
        if (player != INVALID && ai != INVALID) begin
            if (player == ai) begin
                result = RES_TIE;
            end else if ((player == PAPER    && ai == ROCK)     ||
                         (player == SCISSORS && ai == PAPER)    ||
                         (player == ROCK     && ai == SCISSORS)) begin
                result = RES_PLAYER;
            end else begin
                result = RES_AI;
            end
        end
    end

endmodule

// File: rtl/round_judge.sv
// Round judge: accepts a player move, waits for the predictor, scores the round,
// holds the result for a display period and stops the game at the win/round limit.
module round_judge #(
    parameter int WIN_LIMIT   = 9,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int MAX_ROUNDS  = round_judge_pkg::MAX_ROUNDS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       move_valid,
    input  logic [1:0] move,
    input  logic       ai_valid,
    input  logic [1:0] ai_choice,
    output logic [3:0] combination,
    output logic       combination_valid,
    output logic [1:0] result,
    output logic [3:0] player_score,
    output logic [3:0] ai_score,
    output logic [5:0] round_count,
    output logic       game_over,
    output logic       busy
);
    import round_judge_pkg::*;

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [3:0] WIN_Q = 4'(WIN_LIMIT);
    localparam logic [5:0] MAX_Q = 6'(MAX_ROUNDS);

    state_e            state_q, state_d;
    logic [1:0]        move_q, move_d;
    logic [1:0]        ai_q, ai_d;
    logic [1:0]        result_q, result_d;
    logic [3:0]        comb_q, comb_d;
    logic              cv_q, cv_d;
    logic [3:0]        ps_q, ps_d;
    logic [3:0]        as_q, as_d;
    logic [5:0]        rc_q, rc_d;
    logic              go_q, go_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        outcome;

    rps_outcome u_outcome (
        .player (move_q),
        .ai     (ai_q),
        .result (outcome)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            move_q   <= ROCK;
            ai_q     <= ROCK;
            result_q <= RES_NONE;
            comb_q   <= '0;
            cv_q     <= 1'b0;
            ps_q     <= '0;
            as_q     <= '0;
            rc_q     <= '0;
            go_q     <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            move_q   <= move_d;
            ai_q     <= ai_d;
            result_q <= result_d;
            comb_q   <= comb_d;
            cv_q     <= cv_d;
            ps_q     <= ps_d;
            as_q     <= as_d;
            rc_q     <= rc_d;
            go_q     <= go_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        move_d   = move_q;
        ai_d     = ai_q;
        result_d = result_q;
        comb_d   = comb_q;
        cv_d     = 1'b0;
        ps_d     = ps_q;
        as_d     = as_q;
        rc_d     = rc_q;
        go_d     = go_q;
        hold_d   = hold_q;

        case (state_q)
            S_IDLE: begin
                if (move_valid && move != INVALID) begin
                    move_d  = move;
                    state_d = S_WAIT_AI;
                end
            end
            S_WAIT_AI: begin
                if (ai_valid) begin
                    // An invalid predictor move is treated as rock.
                    ai_d    = (ai_choice == INVALID) ? ROCK : ai_choice;
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                result_d = outcome;
                comb_d   = {ai_q, move_q};
                cv_d     = 1'b1;
                if (outcome == RES_PLAYER && ps_q < WIN_Q) ps_d = ps_q + 4'd1;
                if (outcome == RES_AI     && as_q < WIN_Q) as_d = as_q + 4'd1;
                if (rc_q < MAX_Q) rc_d = rc_q + 6'd1;
                go_d    = (ps_d >= WIN_Q) || (as_d >= WIN_Q) || (rc_d >= MAX_Q);
                hold_d  = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q >= HOLD_LAST) begin
                    state_d = go_q ? S_DONE : S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign combination       = comb_q;
    assign combination_valid = cv_q;
    assign result            = result_q;
    assign player_score      = ps_q;
    assign ai_score          = as_q;
    assign round_count       = rc_q;
    assign game_over         = go_q;
    assign busy              = (state_q != S_IDLE);

endmodule
